conv1d_pe_dp: RTL and testbench

Parametrised 1-D convolution processing-element datapath: successor to the single-filter conv datapath, with multi-filter support, stride skipping, filter retention across rows and ready/valid handshakes on every stream. It buffers one IFMap row in a circular window FIFO and holds up to FILTER_DEPTH filter taps in a scratchpad. For every window position it emits one partial sum per filter. Sits between the global-buffer streamers and the psum collector.

---
 rtl/conv1d_pe_dp.sv | 170 +++++++++++++++++
 tb/tb_conv1d_pe_dp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/conv1d_pe_dp.sv
// conv1d_pe_dp: 1-D convolution processing-element datapath.
// Buffers one IFMap row in a circular window FIFO and keeps up to
// FILTER_DEPTH taps, covering every filter, in a scratchpad. For each window
// position it produces one partial sum per filter. The window then steps by
// `stride` elements.
// Ports:
//   clk, rstn             clock, async active-low reset
//   start, keep_filters   begin a row (IDLE only); reuse stored filters
//   stride, filter_size, num_filters   row config, latched at start
//   filt_valid/ready/data             filter tap load stream
//   ifmap_valid/ready/data/last       IFMap element stream
//   psum_valid/ready/data/fid         partial-sum output stream
//   done                  one-cycle end-of-row pulse
//   cfg_err               last start carried an illegal config
module conv1d_pe_dp #(
  parameter int DATA_WIDTH   = 8,
  parameter int PSUM_WIDTH   = 20,
  parameter int IFMAP_DEPTH  = 16,
  parameter int FILTER_DEPTH = 32,
  parameter int STRIDE_SIZE  = 3,
  parameter int FSIZE_WIDTH  = 5,
  parameter int NF_WIDTH     = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   keep_filters,
  input  logic [STRIDE_SIZE-1:0] stride,
  input  logic [FSIZE_WIDTH-1:0] filter_size,
  input  logic [NF_WIDTH-1:0]    num_filters,
  input  logic                   filt_valid,
  output logic                   filt_ready,
  input  logic [DATA_WIDTH-1:0]  filt_data,
  input  logic                   ifmap_valid,
  output logic                   ifmap_ready,
  input  logic [DATA_WIDTH-1:0]  ifmap_data,
  input  logic                   ifmap_last,
  output logic                   psum_valid,
  input  logic                   psum_ready,
  output logic [PSUM_WIDTH-1:0]  psum_data,
  output logic [NF_WIDTH-1:0]    psum_fid,
  output logic                   done,
  output logic                   cfg_err
);
  localparam int IW = $clog2(IFMAP_DEPTH);
  localparam int CW = $clog2(IFMAP_DEPTH + 1);
  localparam int FW = $clog2(FILTER_DEPTH);
  localparam int TW = NF_WIDTH + FSIZE_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD_FILTER, WAIT_DATA, MAC, EMIT, ADVANCE, DONE} state_t;
  state_t state, nxt;

  logic [DATA_WIDTH-1:0]  win_mem  [IFMAP_DEPTH];
  logic [DATA_WIDTH-1:0]  filt_mem [FILTER_DEPTH];

  logic [STRIDE_SIZE-1:0] st_r, skip_pend;
  logic [FSIZE_WIDTH-1:0] fs_r, k;
  logic [NF_WIDTH-1:0]    nf_r, f;
  logic [TW-1:0]          ntaps_r, fl_idx, fbase;
  logic [PSUM_WIDTH-1:0]  acc;
  logic [IW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count, d;
  logic                   last_seen;

  logic [TW-1:0]          cfg_taps;
  logic                   cfg_bad, push, fpush, win_ok;
  logic [2*DATA_WIDTH-1:0] prod;

  // Sums fed here never reach 2*IFMAP_DEPTH, so one conditional subtract wraps.
  function automatic logic [IW-1:0] wrap(input logic [31:0] p);
    return (p >= IFMAP_DEPTH) ? IW'(p - IFMAP_DEPTH) : IW'(p);
  endfunction

  assign cfg_taps = TW'(num_filters) * TW'(filter_size);
  assign cfg_bad  = (stride == '0) || (filter_size == '0) || (num_filters == '0) ||
                    (32'(filter_size) > IFMAP_DEPTH) || (32'(cfg_taps) > FILTER_DEPTH);

  assign filt_ready  = (state == LOAD_FILTER);
  assign ifmap_ready = (state != IDLE) && (state != DONE) &&
                       (32'(count) < IFMAP_DEPTH) && !last_seen;
  assign psum_valid  = (state == EMIT);
  assign psum_data   = acc;
  assign psum_fid    = f;
  assign done        = (state == DONE);

  assign push   = ifmap_valid && ifmap_ready;
  assign fpush  = filt_valid && filt_ready;
  assign win_ok = 32'(count) >= 32'(fs_r);

  // Entries discarded this cycle: only ADVANCE drops data, never more than held.
  always_comb begin
    d = '0;
    if (state == ADVANCE)
      d = (32'(count) < 32'(skip_pend)) ? count : CW'(skip_pend);
  end

  assign prod = win_mem[wrap(32'(rd_ptr) + 32'(k))] *
                filt_mem[FW'(32'(fbase) + 32'(k))];

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:        if (start && !cfg_bad) nxt = keep_filters ? WAIT_DATA : LOAD_FILTER;
      LOAD_FILTER: if (fpush && fl_idx == ntaps_r - 1'b1) nxt = WAIT_DATA;
      WAIT_DATA:   if (win_ok) nxt = MAC;
                   else if (last_seen) nxt = DONE;
      MAC:         if (k == fs_r - 1'b1) nxt = EMIT;
      EMIT:        if (psum_ready) nxt = (f == nf_r - 1'b1) ? ADVANCE : MAC;
      ADVANCE:     if (32'(skip_pend) == 32'(d)) nxt = WAIT_DATA;
                   else if (count == '0 && last_seen) nxt = DONE;
      DONE:        nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (push)  win_mem[wr_ptr] <= ifmap_data;
    if (fpush) filt_mem[FW'(fl_idx)] <= filt_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_r <= '0; fs_r <= '0; nf_r <= '0; ntaps_r <= '0;
      skip_pend <= '0; k <= '0; f <= '0; fl_idx <= '0; fbase <= '0;
      acc <= '0; rd_ptr <= '0; wr_ptr <= '0; count <= '0;
      last_seen <= 1'b0; cfg_err <= 1'b0;
    end else begin
      // FIFO bookkeeping; a flush at start overrides below.
      if (push) begin
        wr_ptr <= wrap(32'(wr_ptr) + 32'd1);
        if (ifmap_last) last_seen <= 1'b1;
      end
      rd_ptr <= wrap(32'(rd_ptr) + 32'(d));
      count  <= count + CW'(push) - d;

      case (state)
        IDLE: if (start) begin
          if (cfg_bad) cfg_err <= 1'b1;
          else begin
            cfg_err <= 1'b0;
            st_r <= stride; fs_r <= filter_size; nf_r <= num_filters;
            ntaps_r <= cfg_taps; fl_idx <= '0;
            rd_ptr <= '0; wr_ptr <= '0; count <= '0; last_seen <= 1'b0;
          end
        end
        LOAD_FILTER: if (fpush) fl_idx <= fl_idx + 1'b1;
        WAIT_DATA: if (win_ok) begin
          acc <= '0; f <= '0; k <= '0; fbase <= '0;
        end
        MAC: begin
          acc <= acc + PSUM_WIDTH'(prod);
          k   <= k + 1'b1;
        end
        EMIT: if (psum_ready) begin
          if (f != nf_r - 1'b1) begin
            f <= f + 1'b1; k <= '0; acc <= '0;
            fbase <= fbase + TW'(fs_r);
          end else skip_pend <= st_r;
        end
        ADVANCE: skip_pend <= skip_pend - STRIDE_SIZE'(d);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1d_pe_dp.sv
// Directed bench for conv1d_pe_dp: drives the filter and IFMap streams and
// compares every accepted psum against hand-computed values.
module tb_conv1d_pe_dp;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        start = 0, keep_filters = 0;
  logic [2:0]  stride = 0;
  logic [4:0]  filter_size = 0;
  logic [2:0]  num_filters = 0;
  logic        filt_valid = 0, ifmap_valid = 0, ifmap_last = 0, psum_ready = 1;
  logic [7:0]  filt_data = 0, ifmap_data = 0;
  logic        filt_ready, ifmap_ready, psum_valid, done, cfg_err;
  logic [19:0] psum_data;
  logic [2:0]  psum_fid;

  int nvec = 0, nerr = 0;
  int filt_q[$], ifm_q[$], exp_q[$], fid_q[$];

  conv1d_pe_dp dut (
    .clk(clk), .rstn(rstn), .start(start), .keep_filters(keep_filters),
    .stride(stride), .filter_size(filter_size), .num_filters(num_filters),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
    .ifmap_last(ifmap_last), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .psum_fid(psum_fid), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic feed_filt();
    int i = 0, cyc = 0;
    while (i < filt_q.size() && cyc < 600) begin
      @(negedge clk); cyc++;
      filt_valid = 1; filt_data = 8'(filt_q[i]);
      if (filt_ready) i++;
    end
    @(negedge clk); filt_valid = 0;
  endtask

  task automatic feed_ifm();
    int i = 0, cyc = 0;
    while (i < ifm_q.size() && cyc < 600) begin
      @(negedge clk); cyc++;
      ifmap_valid = 1; ifmap_data = 8'(ifm_q[i]); ifmap_last = (i == ifm_q.size() - 1);
      if (ifmap_ready) i++;
    end
    @(negedge clk); ifmap_valid = 0; ifmap_last = 0;
  endtask

  // hold > 0: keep psum_ready low for that many cycles of the first psum.
  task automatic monitor(input int hold, input bit no_filt);
    int cyc = 0, nps = 0, fr = 0, hcnt = 0;
    bit seen_done = 0;
    logic [19:0] hd = '0;
    logic [2:0]  hf = '0;
    while (!seen_done && cyc < 600) begin
      @(negedge clk); cyc++;
      if (filt_ready) fr++;
      if (psum_valid && !psum_ready) begin
        if (hcnt == 0) begin hd = psum_data; hf = psum_fid; end
        hcnt++;
        if (hcnt >= hold) begin
          chk("hold_data", psum_data, hd);
          chk("hold_fid", psum_fid, hf);
          chk("ifmap_full_ready", ifmap_ready, 0);
          psum_ready = 1;
        end
      end
      if (psum_valid && psum_ready) begin
        if (nps < exp_q.size()) begin
          chk($sformatf("psum[%0d]", nps), psum_data, exp_q[nps]);
          chk($sformatf("fid[%0d]", nps), psum_fid, fid_q[nps]);
        end
        nps++;
      end
      if (done) seen_done = 1;
    end
    chk("psum_count", nps, exp_q.size());
    chk("done_seen", seen_done, 1);
    if (no_filt) chk("filt_ready_cycles", fr, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_row(input int fs, input int st, input int nf, input bit keep, input int hold);
    @(negedge clk);
    start = 1; keep_filters = keep;
    filter_size = 5'(fs); stride = 3'(st); num_filters = 3'(nf);
    psum_ready = (hold == 0);
    @(negedge clk);
    start = 0; keep_filters = 0;
    chk("cfg_err_legal", cfg_err, 0);
    fork
      if (!keep) feed_filt();
      feed_ifm();
      monitor(hold, keep);
    join
    psum_ready = 1;
  endtask

  task automatic bad_cfg(input string tag, input int fs, input int nf);
    @(negedge clk);
    start = 1; filter_size = 5'(fs); num_filters = 3'(nf); stride = 3'd1;
    @(negedge clk);
    start = 0;
    chk({tag, "_cfg_err"}, cfg_err, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_filt_ready"}, filt_ready, 0);
    chk({tag, "_ifmap_ready"}, ifmap_ready, 0);
    chk({tag, "_cfg_err_held"}, cfg_err, 1);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_filt_ready"}, filt_ready, 0);
    chk({tag, "_ifmap_ready"}, ifmap_ready, 0);
    chk({tag, "_psum_valid"}, psum_valid, 0);
    chk({tag, "_psum_data"}, psum_data, 0);
    chk({tag, "_psum_fid"}, psum_fid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  initial begin
    #1 reset_outputs("rst");
    repeat (2) @(negedge clk);
    rstn = 1;

    // fs=3, stride=1, filter [1,2,3], IFMap 1..5
    filt_q = '{1, 2, 3}; ifm_q = '{1, 2, 3, 4, 5};
    exp_q = '{14, 20, 26}; fid_q = '{0, 0, 0};
    run_row(3, 1, 1, 0, 0);

    // stride 2: element 5 is a short tail
    exp_q = '{14, 26}; fid_q = '{0, 0};
    run_row(3, 2, 1, 0, 0);

    // stride 4 reusing stored filter
    exp_q = '{14}; fid_q = '{0};
    run_row(3, 4, 1, 1, 0);

    // two filters
    filt_q = '{1, 0, 0, 0, 0, 1}; ifm_q = '{5, 6, 7};
    exp_q = '{5, 7}; fid_q = '{0, 1};
    run_row(3, 1, 2, 0, 0);

    // keep_filters with new data
    ifm_q = '{8, 9, 10};
    exp_q = '{8, 10}; fid_q = '{0, 1};
    run_row(3, 1, 2, 1, 0);

    // back-pressure: 20-element row, psum_ready low until the FIFO fills
    filt_q = '{1, 2, 3};
    ifm_q.delete(); exp_q.delete(); fid_q.delete();
    for (int i = 1; i <= 20; i++) ifm_q.push_back(i);
    for (int i = 0; i < 18; i++) begin exp_q.push_back(6 * i + 14); fid_q.push_back(0); end
    run_row(3, 1, 1, 0, 14);

    // illegal configs, then a legal start clears cfg_err
    bad_cfg("fs17", 17, 1);
    bad_cfg("nf3fs11", 11, 3);
    ifm_q = '{1, 2, 3, 4, 5};
    exp_q = '{14, 20, 26}; fid_q = '{0, 0, 0};
    run_row(3, 1, 1, 0, 0);

    // reset in the middle of MAC
    @(negedge clk);
    start = 1; filter_size = 5'd3; num_filters = 3'd1; stride = 3'd1;
    filt_valid = 1; filt_data = 8'd1; ifmap_valid = 1; ifmap_data = 8'd2;
    repeat (6) @(posedge clk);
    start = 0;
    #1 chk("mid_mac_acc", psum_data, 2);
    #1 rstn = 0;
    #1 reset_outputs("async_rst");
    filt_valid = 0; ifmap_valid = 0;
    repeat (3) begin @(negedge clk); chk("rst_no_done", done, 0); end
    rstn = 1;
    run_row(3, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
